// File: rtl/disp_pkg.sv
// disp_pkg
// Shared constants for the multiplexed seven-segment display blocks.
//   NUM_DIGITS : number of digit slots scanned by the driver
//   SEG_OFF    : active-low segment pattern with every segment dark
//   AN_OFF     : active-low anode pattern with every digit disabled
//   SEG_TABLE  : active-low {g,f,e,d,c,b,a} pattern for hex values 0..F
package disp_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [5:0] AN_OFF  = 6'b111111;

   typedef logic [3:0] digit_t;

   // Entry k holds the pattern for hex value k (entry 15 is listed first).
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0001110,   // F
      7'b0000110,   // E
      7'b0100001,   // d
      7'b1000110,   // C
      7'b0000011,   // b
      7'b0001000,   // A
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg
// Combinational hex-digit to seven-segment decoder.
//   value_i : 4-bit hex value
//   seg_o   : active-low segments {g,f,e,d,c,b,a}
module hex_to_seg
   import disp_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [6:0] seg_o
);

   // Every 4-bit value has a table entry, so no default case is needed.
   always_comb begin
      seg_o = SEG_TABLE[value_i];
   end

endmodule

// File: rtl/digit_scan_driver.sv
// digit_scan_driver
// Time-multiplexed driver for a six-digit common-anode seven-segment display.
// A prescaler divides clk down to one tick per digit slot; each tick moves
// the scan to the next slot, and the six digits are latched as one frame
// whenever the scan wraps back to slot 0.
//   clk         : sole clock, rising edge
//   rst_n       : asynchronous active-low reset
//   d1..d6      : digit values, d1 is slot 0, d6 is slot 5
//   blank       : 1 turns every digit dark (scan keeps running)
//   an          : active-low digit enables, an[k] drives slot k
//   seg         : active-low segments {g,f,e,d,c,b,a}
//   frame_start : one-clock pulse when slot 0 becomes active
module digit_scan_driver
   import disp_pkg::*;
#(
   parameter int CLK_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] d4,
   input  logic [3:0] d5,
   input  logic [3:0] d6,
   input  logic       blank,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       frame_start
);

   localparam int            PW        = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [2:0]    LAST_SLOT = 3'(NUM_DIGITS - 1);

   logic [PW-1:0]                presc_q, presc_d;
   logic [2:0]                   index_q, index_d;
   digit_t [NUM_DIGITS-1:0]      frame_q, frame_d;
   logic                         started_q, started_d;
   logic [5:0]                   an_q, an_d;
   logic [6:0]                   seg_q, seg_d;
   logic                         fs_q, fs_d;
   logic                         tick;
   logic                         wrap;
   logic [6:0]                   slotSeg;

   hex_to_seg u_hex_to_seg (
      .value_i (frame_q[index_q]),
      .seg_o   (slotSeg)
   );

   // Scan state: the index resets to the last slot so that the first tick
   // wraps to slot 0 and captures live digits. started_q keeps the display
   // dark until that first frame exists, so the zero reset frame never shows.
   // Outputs are registered from the current index/frame, which puts them
   // one clock behind the tick edge that moved the scan. frame_start fires on
   // the first clock of slot 0 (prescaler just wrapped), independent of blank.
   always_comb begin
      tick      = (presc_q == PRESC_MAX);
      wrap      = tick && (index_q == LAST_SLOT);
      presc_d   = tick ? '0 : presc_q + 1'b1;
      index_d   = index_q;
      frame_d   = frame_q;
      started_d = started_q | wrap;
      if (tick) begin
         index_d = (index_q == LAST_SLOT) ? 3'd0 : index_q + 3'd1;
      end
      if (wrap) begin
         frame_d = {d6, d5, d4, d3, d2, d1};
      end
      if (blank || !started_q) begin
         an_d  = AN_OFF;
         seg_d = SEG_OFF;
      end else begin
         an_d  = ~(6'b000001 << index_q);
         seg_d = slotSeg;
      end
      fs_d = (presc_q == '0) && (index_q == 3'd0);
   end

   // State and output registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         index_q   <= LAST_SLOT;
         frame_q   <= '0;
         started_q <= 1'b0;
         an_q      <= AN_OFF;
         seg_q     <= SEG_OFF;
         fs_q      <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         index_q   <= index_d;
         frame_q   <= frame_d;
         started_q <= started_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         fs_q      <= fs_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb_digit_scan_driver
// Self-checking bench for digit_scan_driver. A CLK_DIV=4 instance runs the
// directed scan/blank/reset sequence; a CLK_DIV=2 instance sweeps d1 over
// every hex value. A clock-count model predicts every output each cycle.
module tb_digit_scan_driver;

   logic       clk;
   logic       rst_n;
   logic [3:0] d1, d2, d3, d4, d5, d6;
   logic       blank;
   logic [5:0] an1;
   logic [6:0] seg1;
   logic       fs1;

   logic [3:0] d1b;
   logic [3:0] zero4;
   logic       zero1;
   logic [5:0] an2;
   logic [6:0] seg2;
   logic       fs2;

   int checks   = 0;
   int failures = 0;

   digit_scan_driver #(.CLK_DIV(4)) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .d1          (d1),
      .d2          (d2),
      .d3          (d3),
      .d4          (d4),
      .d5          (d5),
      .d6          (d6),
      .blank       (blank),
      .an          (an1),
      .seg         (seg1),
      .frame_start (fs1)
   );

   digit_scan_driver #(.CLK_DIV(2)) dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .d1          (d1b),
      .d2          (zero4),
      .d3          (zero4),
      .d4          (zero4),
      .d5          (zero4),
      .d6          (zero4),
      .blank       (zero1),
      .an          (an2),
      .seg         (seg2),
      .frame_start (fs2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference segment patterns, written out independently of the design.
   function automatic logic [6:0] tbSeg(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // n counts rising edges since reset release. The first tick is edge div;
   // from edge div+1 on, each slot is shown for div edges in order 0..5.
   function automatic bit modelLit(input int n, input int div, input logic blk);
      return (!blk) && (n > div);
   endfunction

   function automatic int modelSlot(input int n, input int div);
      return ((n - div - 1) / div) % 6;
   endfunction

   function automatic logic [5:0] modelAn(input int n, input int div, input logic blk);
      logic [5:0] one;
      one = 6'b000001;
      if (!modelLit(n, div, blk)) return 6'b111111;
      return ~(one << modelSlot(n, div));
   endfunction

   function automatic logic modelFs(input int n, input int div);
      return (n > div) && (((n - div - 1) % (6 * div)) == 0);
   endfunction

   logic [5:0] exp1An  = 6'b111111;
   logic [6:0] exp1Seg = 7'b1111111;
   logic       exp1Fs  = 1'b0;
   int         n1      = 0;
   logic [3:0] f1 [6];

   logic [5:0] exp2An  = 6'b111111;
   logic [6:0] exp2Seg = 7'b1111111;
   logic       exp2Fs  = 1'b0;
   int         n2      = 0;
   logic [3:0] f2 [6];

   // Model for the CLK_DIV=4 instance: frames are captured on edges where
   // n mod 24 == 4 and become visible on the following edge.
   always @(posedge clk or negedge rst_n) begin : model1
      int n;
      if (!rst_n) begin
         n1      <= 0;
         exp1An  <= 6'b111111;
         exp1Seg <= 7'b1111111;
         exp1Fs  <= 1'b0;
         for (int i = 0; i < 6; i++) f1[i] <= 4'h0;
      end else begin
         n = n1 + 1;
         n1      <= n;
         exp1An  <= modelAn(n, 4, blank);
         exp1Seg <= modelLit(n, 4, blank) ? tbSeg(f1[modelSlot(n, 4)]) : 7'b1111111;
         exp1Fs  <= modelFs(n, 4);
         if ((n % 24) == 4) begin
            f1[0] <= d1; f1[1] <= d2; f1[2] <= d3;
            f1[3] <= d4; f1[4] <= d5; f1[5] <= d6;
         end
      end
   end

   // Model for the CLK_DIV=2 instance (blank tied low).
   always @(posedge clk or negedge rst_n) begin : model2
      int n;
      if (!rst_n) begin
         n2      <= 0;
         exp2An  <= 6'b111111;
         exp2Seg <= 7'b1111111;
         exp2Fs  <= 1'b0;
         for (int i = 0; i < 6; i++) f2[i] <= 4'h0;
      end else begin
         n = n2 + 1;
         n2      <= n;
         exp2An  <= modelAn(n, 2, zero1);
         exp2Seg <= modelLit(n, 2, zero1) ? tbSeg(f2[modelSlot(n, 2)]) : 7'b1111111;
         exp2Fs  <= modelFs(n, 2);
         if ((n % 12) == 2) begin
            f2[0] <= d1b; f2[1] <= zero4; f2[2] <= zero4;
            f2[3] <= zero4; f2[4] <= zero4; f2[5] <= zero4;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v1, input logic [3:0] v2, input logic [3:0] v3,
                                input logic [3:0] v4, input logic [3:0] v5, input logic [3:0] v6,
                                input logic blk);
      d1 = v1; d2 = v2; d3 = v3; d4 = v4; d5 = v5; d6 = v6;
      blank = blk;
   endtask

   task automatic waitEdges(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      checkOutput("an1",  {2'b00, an1},  {2'b00, exp1An});
      checkOutput("seg1", {1'b0, seg1},  {1'b0, exp1Seg});
      checkOutput("fs1",  {7'b0, fs1},   {7'b0, exp1Fs});
      checkOutput("an2",  {2'b00, an2},  {2'b00, exp2An});
      checkOutput("seg2", {1'b0, seg2},  {1'b0, exp2Seg});
      checkOutput("fs2",  {7'b0, fs2},   {7'b0, exp2Fs});
   end

   // Edge numbers in comments count rising edges after reset release.
   task automatic checkStartup(input string tag);
      waitEdges(4);
      checkOutput({tag, "_e4_an"}, {2'b00, an1}, 8'b00111111);
      waitEdges(1);
      checkOutput({tag, "_e5_an"},  {2'b00, an1}, 8'b00111110);
      checkOutput({tag, "_e5_seg"}, {1'b0, seg1}, 8'b01111001);
      checkOutput({tag, "_e5_fs"},  {7'b0, fs1},  8'd1);
      waitEdges(4);
      checkOutput({tag, "_e9_an"},  {2'b00, an1}, 8'b00111101);
      checkOutput({tag, "_e9_seg"}, {1'b0, seg1}, 8'b01000000);
      checkOutput({tag, "_e9_fs"},  {7'b0, fs1},  8'd0);
   endtask

   initial begin
      zero4 = 4'h0;
      zero1 = 1'b0;
      d1b   = 4'h0;
      rst_n = 1'b0;
      applyStimulus(4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("rst_an",  {2'b00, an1}, 8'b00111111);
      checkOutput("rst_seg", {1'b0, seg1}, 8'b01111111);
      checkOutput("rst_fs",  {7'b0, fs1},  8'd0);
      rst_n = 1'b1;

      checkStartup("boot");
      // edge 29: second frame begins, 24 clocks after the first
      waitEdges(20);
      checkOutput("e29_fs", {7'b0, fs1},  8'd1);
      checkOutput("e29_an", {2'b00, an1}, 8'b00111110);

      // edge 42: slot 3 active, change d1 mid-frame
      waitEdges(13);
      applyStimulus(4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b0);
      waitEdges(11);
      checkOutput("e53_an",  {2'b00, an1}, 8'b00111110);
      checkOutput("e53_seg", {1'b0, seg1}, 8'b01000000);
      checkOutput("e53_fs",  {7'b0, fs1},  8'd1);

      // edge 62: mid slot 2, blank for 10 sampled clocks
      waitEdges(9);
      blank = 1'b1;
      waitEdges(1);
      checkOutput("blank_an",  {2'b00, an1}, 8'b00111111);
      checkOutput("blank_seg", {1'b0, seg1}, 8'b01111111);
      waitEdges(9);
      blank = 1'b0;
      waitEdges(1);
      checkOutput("unblank_an",  {2'b00, an1}, 8'b00011111);
      checkOutput("unblank_seg", {1'b0, seg1}, 8'b01111001);
      waitEdges(4);
      checkOutput("e77_fs", {7'b0, fs1},  8'd1);
      checkOutput("e77_an", {2'b00, an1}, 8'b00111110);

      // blank across the frame boundary at edge 101
      waitEdges(22);
      blank = 1'b1;
      waitEdges(2);
      checkOutput("blankfs_fs", {7'b0, fs1},  8'd1);
      checkOutput("blankfs_an", {2'b00, an1}, 8'b00111111);
      blank = 1'b0;

      // edge 118: slot 4 active, asynchronous reset pulse
      waitEdges(17);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_an",  {2'b00, an1}, 8'b00111111);
      checkOutput("async_seg", {1'b0, seg1}, 8'b01111111);
      checkOutput("async_fs",  {7'b0, fs1},  8'd0);
      applyStimulus(4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      checkStartup("rerun");

      // CLK_DIV=2 instance: each value is captured once per 12-clock frame
      for (int v = 0; v < 16; v++) begin
         @(negedge clk);
         d1b = 4'(v);
         repeat (12) @(negedge clk);
      end
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/digit_scan_driver.md
DIGIT_SCAN_DRIVER -- requirements
Module: digit_scan_driver

Interface
REQ-001 The block SHALL have one parameter: CLK_DIV, default 50000, clocks per digit slot; legal range 2..2^20.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 d1..d6  input  4 each  digit values from the upstream digit-producing stage; d1 is slot 0 and d6 is slot 5.
REQ-005 blank  input  1  when 1, all digits dark.
REQ-006 an  output  6  digit enables, active-low; an[k] drives slot k.
REQ-007 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 frame_start  output  1  one-clock pulse, registered with an/seg, marking slot 0 becoming active.

Function
REQ-009 The prescaler SHALL count 0..CLK_DIV-1 and wrap; tick = (prescaler == CLK_DIV-1), combinational and internal.
REQ-010 On a clock edge with tick=1, slot index SHALL advance modulo 6 (5 -> 0).
REQ-011 On a tick edge where index wraps 5 -> 0, d1..d6 SHALL be captured into a frame register together, so one frame never mixes old and new digits.
REQ-012 d1..d6 changes between captures SHALL NOT affect seg.
REQ-013 an, seg and frame_start SHALL be registered from the updated index/frame, with a latency of exactly 1 clock after the tick edge.
REQ-014 Outside blank, exactly one an bit SHALL be low: an = ~(6'b1 << index).
REQ-015 seg SHALL be the active-low hex decode of frame[index]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-016 blank=1 SHALL force an=6'b111111 and seg=7'b1111111 from the next clock.
REQ-017 Under blank, the prescaler, index and frame capture SHALL keep running.
REQ-018 When blank deasserts, the display SHALL resume on the current slot at the next clock without a restart.
REQ-019 frame_start SHALL pulse once per 6*CLK_DIV clocks, aligned with an=6'b111110; it SHALL still pulse while blank=1.
REQ-020 All d inputs are 4-bit, so no out-of-range digit exists; no saturation is required.

Reset
REQ-021 Asserting rst_n=0 SHALL immediately set: prescaler=0, index=5, frame=all zero, an=6'b111111, seg=7'b1111111, frame_start=0.
REQ-022 Because index resets to 5, the first tick after reset SHALL wrap to slot 0 and capture live d1..d6, so the first displayed frame is never the zero reset frame.
REQ-023 A reset asserted mid-slot or mid-frame SHALL discard the partial frame.
REQ-024 After rst_n is released, the sequence SHALL restart exactly as in REQ-021/022.
REQ-025 Deassertion of rst_n is synchronous to clk, which is an integration responsibility.

Structure
REQ-026 The shared package disp_pkg SHALL hold the following, for reuse by the other display blocks:
- NUM_DIGITS=6
- SEG_OFF=7'b1111111
- AN_OFF=6'b111111
- the 16-entry segment table
REQ-027 The decode SHALL be a separate combinational sub-module hex_to_seg (4-bit in, 7-bit active-low out).
REQ-028 The prescaler width SHALL be $clog2(CLK_DIV).
REQ-029 The top module SHALL contain no other sub-modules.

Verification (CLK_DIV=4 unless stated)
REQ-030 Reset release with d1..d6=1,0,1,1,0,1 -> edges 1-4 an=111111; edge 5 an=111110, seg=1111001, frame_start=1; edge 9 an=111101, seg=1000000.
REQ-031 Full scan -> an steps 111110, 111101, 111011, 110111, 101111, 011111, then back to 111110, each held 4 clocks; frame_start period = 24 clocks.
REQ-032 Change d1 from 1 to 0 while slot 3 is active -> slot 0 of the current frame is unaffected; the next frame shows seg=1000000 on an=111110.
REQ-033 blank=1 for 10 clocks mid-slot-2 -> an=111111, seg=1111111 one clock after assertion; on release, the slot that the free-running index now points to is shown next clock; frame_start timing is unchanged.
REQ-034 rst_n pulsed low during slot 4 -> outputs go dark immediately, with no clock required; after release the REQ-030 timing repeats exactly.
REQ-035 Sweep d1 over 0..F with CLK_DIV=2 -> seg matches the REQ-015 table for every value.
